// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel: two-stage pipelined N-channel word multiplexer with optional
// bit-reversal and valid/ready flow control.
//
// Stage 1 selects channel in_sel from in_data (zero and flagged when in_sel is
// out of range). Stage 2 optionally bit-reverses the word and presents it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input transaction present
//   in_ready     block accepts input this cycle
//   in_data      NCH packed words, channel k at [k*WIDTH +: WIDTH]
//   in_sel       channel index
//   in_rev       bit-reverse the selected word
//   out_valid    output word present
//   out_ready    downstream accepts output
//   out_data     selected (optionally reversed) word
//   out_ch       raw channel index that produced out_data
//   out_err      in_sel was out of range for this word
//   busy         either stage holds a valid word
module mux_pipe_sel #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NCH   = 4,
   localparam int unsigned SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic [SELW-1:0]        in_sel,
   input  logic                   in_rev,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_ch,
   output logic                   out_err,
   output logic                   busy
);

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_word_q,  s1_word_d;
   logic             s1_rev_q,   s1_rev_d;
   logic [SELW-1:0]  s1_ch_q,    s1_ch_d;
   logic             s1_err_q,   s1_err_d;

   // Stage 2 state
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q,  s2_data_d;
   logic [SELW-1:0]  s2_ch_q,    s2_ch_d;
   logic             s2_err_q,   s2_err_d;

   logic             s2_adv, s1_adv;
   logic [WIDTH-1:0] sel_word;
   logic             sel_err;
   logic [WIDTH-1:0] rev_word;

   // A stage advances when it is empty or its consumer takes its word.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Channel select; out-of-range indices match no channel and leave zero.
   always_comb begin
      sel_word = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (in_sel == SELW'(k)) begin
            sel_word = in_data[k*WIDTH +: WIDTH];
         end
      end
      sel_err = (32'(in_sel) >= NCH);
   end

   // Bit reversal; for odd WIDTH the middle bit maps onto itself.
   always_comb begin
      rev_word = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         rev_word[i] = s1_word_q[WIDTH-1-i];
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_word_d  = s1_word_q;
      s1_rev_d   = s1_rev_q;
      s1_ch_d    = s1_ch_q;
      s1_err_d   = s1_err_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_word_d = sel_word;
            s1_rev_d  = in_rev;
            s1_ch_d   = in_sel;
            s1_err_d  = sel_err;
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_ch_d    = s2_ch_q;
      s2_err_d   = s2_err_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = s1_rev_q ? rev_word : s1_word_q;
            s2_ch_d   = s1_ch_q;
            s2_err_d  = s1_err_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= '0;
         s1_rev_q   <= 1'b0;
         s1_ch_q    <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_ch_q    <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_word_q  <= s1_word_d;
         s1_rev_q   <= s1_rev_d;
         s1_ch_q    <= s1_ch_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_ch_q    <= s2_ch_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_ch    = s2_ch_q;
   assign out_err   = s2_err_q;
   assign busy      = s1_valid_q || s2_valid_q;

endmodule
